// File: rtl/vga_rx.sv
// Parallel video capture. The video bus is registered once (S1), packed to 16 bits
// and pushed into a small pixel FIFO. Per-frame line length, line count and pixel
// checksum are accumulated between vsync leading edges and latched at frame end.
module vga_rx #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        en_i,
    input  logic        hspol_i,
    input  logic        vspol_i,
    input  logic [1:0]  mode_i,
    input  logic [4:0]  vga_r_i,
    input  logic [5:0]  vga_g_i,
    input  logic [4:0]  vga_b_i,
    input  logic        vga_hsync_i,
    input  logic        vga_vsync_i,
    input  logic        vga_de_i,
    input  logic        clr_i,
    output logic        pix_valid_o,
    input  logic        pix_ready_i,
    output logic [15:0] pix_data_o,
    output logic        pix_sof_o,
    output logic        pix_eol_o,
    output logic [31:0] hvsize_o,
    output logic [15:0] csum_o,
    output logic        frame_done_o,
    output logic        size_err_o,
    output logic        ovf_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PtrOne = 1;

    typedef enum logic [1:0] {StIdle, StWaitVs, StActive} state_e;

    state_e state_q, state_d;

    // S1 capture stage
    logic [4:0] r_q;
    logic [5:0] g_q;
    logic [4:0] b_q;
    logic       de_q;
    logic       hs_q;
    logic       vs_q;
    logic       vs_prev_q;

    // Frame accumulators
    logic [15:0] line_cnt_q;
    logic [15:0] first_len_q;
    logic        first_seen_q;
    logic [15:0] vcnt_q;
    logic [15:0] csum_acc_q;
    logic        sof_pend_q;

    // Latched results and flags
    logic [31:0] hvsize_q;
    logic [15:0] csum_q;
    logic        frame_done_q;
    logic        size_err_q;
    logic        ovf_q;

    // FIFO
    logic [17:0] mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;
    logic        fifo_empty;
    logic        fifo_full;
    logic        do_wr;
    logic        do_rd;
    logic [17:0] head;

    // Decoded control
    logic        st_active;
    logic        st_idle;
    logic        vs_lead;
    logic        frame_start;
    logic        frame_end;
    logic        wr_req;
    logic        line_end;
    logic [15:0] pix_packed;
    logic [15:0] len_inc;
    logic [15:0] vcnt_inc;
    logic        size_err_set;
    logic        ovf_set;

    // Horizontal sync is captured with the rest of the bus; framing relies on de alone.
    logic unused_hs;
    assign unused_hs = hs_q;

    // Register the video bus; sync polarity is normalised before the flop so a
    // polarity change together with the pin level never shows up as an edge.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_q       <= '0;
            g_q       <= '0;
            b_q       <= '0;
            de_q      <= 1'b0;
            hs_q      <= 1'b0;
            vs_q      <= 1'b0;
            vs_prev_q <= 1'b0;
        end else begin
            r_q       <= vga_r_i;
            g_q       <= vga_g_i;
            b_q       <= vga_b_i;
            de_q      <= vga_de_i;
            hs_q      <= vga_hsync_i ^ hspol_i;
            vs_q      <= vga_vsync_i ^ vspol_i;
            vs_prev_q <= vs_q;
        end
    end

    // Pack the S1 pixel according to the selected format
    always_comb begin
        pix_packed = '0;
        unique case (mode_i)
            2'b00:   pix_packed = {8'h00, r_q[4:2], g_q[5:3], b_q[4:3]};
            2'b01:   pix_packed = {4'h0, r_q[4:1], g_q[5:2], b_q[4:1]};
            2'b10:   pix_packed = {1'b0, r_q, g_q[5:1], b_q};
            default: pix_packed = {r_q, g_q, b_q};
        endcase
    end

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    assign vs_lead = vs_q & ~vs_prev_q;

    // FSM next state; dropping enable always wins
    always_comb begin
        state_d = state_q;
        if (!en_i) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:   state_d = StWaitVs;
                StWaitVs: if (vs_lead) state_d = StActive;
                StActive: state_d = StActive;
                default:  state_d = StIdle;
            endcase
        end
    end

    // FSM outputs: decoded frame and pixel events
    always_comb begin
        st_active   = (state_q == StActive);
        st_idle     = (state_q == StIdle);
        frame_start = en_i & vs_lead & ((state_q == StWaitVs) | st_active);
        frame_end   = en_i & vs_lead & st_active;
        wr_req      = en_i & st_active & de_q;
    end

    // Last active pixel of a line: de still high in S1 but already low on the pins
    assign line_end = de_q & ~vga_de_i;

    // Saturating increments for line length and line count
    always_comb begin
        len_inc  = (line_cnt_q == 16'hFFFF) ? 16'hFFFF : line_cnt_q + 16'd1;
        vcnt_inc = (vcnt_q == 16'hFFFF) ? 16'hFFFF : vcnt_q + 16'd1;
    end

    // Per-frame accumulators; partial frames are dropped whenever capture is disabled
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            line_cnt_q   <= '0;
            first_len_q  <= '0;
            first_seen_q <= 1'b0;
            vcnt_q       <= '0;
            csum_acc_q   <= '0;
            sof_pend_q   <= 1'b0;
        end else if (!en_i || st_idle || frame_start) begin
            line_cnt_q   <= '0;
            first_len_q  <= '0;
            first_seen_q <= 1'b0;
            vcnt_q       <= '0;
            csum_acc_q   <= '0;
            sof_pend_q   <= frame_start;
        end else if (st_active && de_q) begin
            csum_acc_q <= csum_acc_q + pix_packed;
            sof_pend_q <= 1'b0;
            if (line_end) begin
                line_cnt_q <= '0;
                vcnt_q     <= vcnt_inc;
                if (!first_seen_q) begin
                    first_len_q  <= len_inc;
                    first_seen_q <= 1'b1;
                end
            end else begin
                line_cnt_q <= len_inc;
            end
        end
    end

    always_comb begin
        size_err_set = en_i & st_active & de_q & line_end & first_seen_q & ~vs_lead &
                       (len_inc != first_len_q);
        ovf_set      = wr_req & fifo_full;
    end

    // Frame results, frame pulse and sticky flags (set beats clear)
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            hvsize_q     <= '0;
            csum_q       <= '0;
            frame_done_q <= 1'b0;
            size_err_q   <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            frame_done_q <= frame_end;
            if (frame_end) begin
                hvsize_q <= {vcnt_q, first_len_q};
                csum_q   <= csum_acc_q;
            end
            size_err_q <= size_err_set | (size_err_q & ~clr_i);
            ovf_q      <= ovf_set | (ovf_q & ~clr_i);
        end
    end

    // FIFO status; full is judged before any same-cycle read
    always_comb begin
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_wr      = wr_req & ~fifo_full;
        do_rd      = ~fifo_empty & pix_ready_i;
    end

    // FIFO pointers; disabling capture flushes the queue
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (!en_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + PtrOne;
            if (do_rd) rd_ptr_q <= rd_ptr_q + PtrOne;
        end
    end

    // FIFO storage; contents are only observed through the valid-gated head
    always_ff @(posedge clk_i) begin
        if (do_wr) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {sof_pend_q, line_end, pix_packed};
        end
    end

    // Head of FIFO presented combinationally, forced to zero when empty
    always_comb begin
        head        = mem_q[rd_ptr_q[AW-1:0]];
        pix_valid_o = ~fifo_empty;
        pix_sof_o   = pix_valid_o & head[17];
        pix_eol_o   = pix_valid_o & head[16];
        pix_data_o  = pix_valid_o ? head[15:0] : 16'h0000;
    end

    assign hvsize_o     = hvsize_q;
    assign csum_o       = csum_q;
    assign frame_done_o = frame_done_q;
    assign size_err_o   = size_err_q;
    assign ovf_o        = ovf_q;

endmodule
